// File: rtl/temp_poll_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : temp_poll_pkg
// Brief    : Shared FSM encoding and default timing/address constants for
//            the I2C temperature poll scheduler.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package temp_poll_pkg;

   typedef logic [2:0] state_t;

   localparam state_t c_st_idle  = 3'd0;
   localparam state_t c_st_req   = 3'd1;
   localparam state_t c_st_wait  = 3'd2;
   localparam state_t c_st_store = 3'd3;
   localparam state_t c_st_next  = 3'd4;

   localparam logic [6:0] c_def_base_addr = 7'h48;
   localparam int         c_def_poll_div  = 1_000_000;
   localparam int         c_def_timeout   = 65_535;

endpackage
`default_nettype wire

// File: rtl/poll_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : poll_timer
// Brief    : Free-running 0..POLL_DIV-1 interval counter that emits the
//            scan-start tick; held at zero while enable is low.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module poll_timer
   import temp_poll_pkg::*;
#(
   parameter int POLL_DIV = c_def_poll_div
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int                 c_cnt_w = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(POLL_DIV - 1);

   logic [c_cnt_w-1:0] r_cnt;
   logic               w_at_last;

   assign w_at_last = (r_cnt == c_last);

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_cnt <= '0;
      end else if (w_at_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = enable && w_at_last;

endmodule
`default_nettype wire

// File: rtl/temp_poll_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : temp_poll_sched
// Brief    : Periodically reads each I2C temperature sensor through an
//            external I2C master and keeps the latest reading per sensor.
//            Optional macro TEMP_POLL_MAX_EN adds max_temp / max_idx outputs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module temp_poll_sched
   import temp_poll_pkg::*;
#(
   parameter int         NUM_SENSORS = 8,
   parameter logic [6:0] BASE_ADDR   = c_def_base_addr,
   parameter int         POLL_DIV    = c_def_poll_div,
   parameter int         TIMEOUT     = c_def_timeout
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   output logic                     i2c_req,
   output logic [6:0]               i2c_addr,
   input  logic                     i2c_done,
   input  logic                     i2c_err,
   input  logic [15:0]              i2c_rdata,
   output logic [16*NUM_SENSORS-1:0] temps,
   output logic [NUM_SENSORS-1:0]   valid,
   output logic                     busy,
   output logic                     scan_done
`ifdef TEMP_POLL_MAX_EN
   ,
   output logic [15:0]              max_temp,
   output logic [2:0]               max_idx
`endif
);

   localparam int                c_to_w     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_to_w-1:0] c_to_last  = c_to_w'(TIMEOUT - 1);
   localparam logic [2:0]        c_idx_last = 3'(NUM_SENSORS - 1);

   state_t                    r_state;
   state_t                    w_next;
   logic [2:0]                r_index;
   logic [c_to_w-1:0]         r_to_cnt;
   logic [16*NUM_SENSORS-1:0] r_temps;
   logic [NUM_SENSORS-1:0]    r_valid;
   logic                      r_scan_done;
   logic                      w_tick;
   logic                      w_commit;
   logic                      w_ok;
   logic                      w_last;

   poll_timer #(
      .POLL_DIV (POLL_DIV)
   ) u_poll_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (w_tick)
   );

   // A simultaneous done+err is an error; a done landing on the timeout cycle still counts.
   assign w_commit = (r_state == c_st_wait) && (i2c_done || i2c_err || (r_to_cnt == c_to_last));
   assign w_ok     = i2c_done && !i2c_err;
   assign w_last   = (r_index == c_idx_last) || !enable;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_idle:  if (w_tick)   w_next = c_st_req;
         c_st_req:                 w_next = c_st_wait;
         c_st_wait:  if (w_commit) w_next = c_st_store;
         c_st_store:               w_next = c_st_next;
         c_st_next:                w_next = w_last ? c_st_idle : c_st_req;
         default:                  w_next = c_st_idle;
      endcase
   end

   always_comb begin
      i2c_req = (r_state == c_st_req) || (r_state == c_st_wait);
      busy    = (r_state != c_st_idle);
   end

   // Result is committed on the edge leaving WAIT so rdata is taken in its own
   // done cycle; STORE is the cycle in which the new value is first visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_index     <= '0;
         r_to_cnt    <= '0;
         r_temps     <= '0;
         r_valid     <= '0;
         r_scan_done <= 1'b0;
      end else begin
         r_scan_done <= (r_state == c_st_next) && w_last;
         r_to_cnt    <= (r_state == c_st_wait) ? r_to_cnt + 1'b1 : '0;
         if ((r_state == c_st_idle) && w_tick) begin
            r_index <= '0;
         end else if ((r_state == c_st_next) && !w_last) begin
            r_index <= r_index + 1'b1;
         end
         if (w_commit) begin
            for (int n = 0; n < NUM_SENSORS; n++) begin
               if (r_index == 3'(n)) begin
                  r_valid[n] <= w_ok;
                  if (w_ok) begin
                     r_temps[16*n +: 16] <= i2c_rdata;
                  end
               end
            end
         end
      end
   end

   assign i2c_addr  = BASE_ADDR + {4'd0, r_index};
   assign temps     = r_temps;
   assign valid     = r_valid;
   assign scan_done = r_scan_done;

`ifdef TEMP_POLL_MAX_EN
   logic [15:0] r_max_temp;
   logic [2:0]  r_max_idx;
   logic [15:0] w_best_temp;
   logic [2:0]  w_best_idx;
   logic        w_any;

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      w_any       = 1'b0;
      w_best_temp = '0;
      w_best_idx  = '0;
      for (int n = 0; n < NUM_SENSORS; n++) begin
         if (r_valid[n] && (!w_any || ($signed(r_temps[16*n +: 16]) > $signed(w_best_temp)))) begin
            w_any       = 1'b1;
            w_best_temp = r_temps[16*n +: 16];
            w_best_idx  = 3'(n);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_max_temp <= '0;
         r_max_idx  <= '0;
      end else if ((r_state == c_st_next) && w_last && w_any) begin
         r_max_temp <= w_best_temp;
         r_max_idx  <= w_best_idx;
      end
   end

   assign max_temp = r_max_temp;
   assign max_idx  = r_max_idx;
`endif

endmodule
`default_nettype wire

// File: doc/temp_poll_sched.md
TEMP_POLL_SCHED -- requirements
Module: temp_poll_sched

Interface
REQ-001 Parameter NUM_SENSORS, default 8, number of I2C temperature sensors scanned (1..8).
REQ-002 Parameter BASE_ADDR, default 7'h48, 7-bit I2C address of sensor 0; sensor n at BASE_ADDR+n.
REQ-003 Parameter POLL_DIV, default 1_000_000, clk cycles between scan starts.
REQ-004 Parameter TIMEOUT, default 65_535, max clk cycles waited per transaction.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  level; permits scans (enable_temps).
REQ-008 i2c_req  out  1  request one 16-bit read from the I2C master.
REQ-009 i2c_addr  out  7  target sensor address; valid while i2c_req high.
REQ-010 i2c_done  in  1  one-cycle pulse, read complete, i2c_rdata valid.
REQ-011 i2c_err  in  1  one-cycle pulse, NACK/bus error.
REQ-012 i2c_rdata  in  16  raw sensor word.
REQ-013 temps  out  16*NUM_SENSORS  latest reading per sensor, sensor n at bits [16n+15:16n].
REQ-014 valid  out  NUM_SENSORS  bit n set when sensor n's last transaction succeeded.
REQ-015 busy  out  1  high while a scan is in progress.
REQ-016 scan_done  out  1  one-cycle pulse at scan end.

Function
REQ-017 Interval counter counts 0..POLL_DIV-1 while enable high, wraps to 0, asserts tick at POLL_DIV-1; held at 0 while enable low.
REQ-018 FSM states: IDLE, REQ, WAIT, STORE, NEXT.
REQ-019 IDLE->REQ on tick with enable high; index cleared to 0; busy rises same edge.
REQ-020 REQ: i2c_req=1, i2c_addr=BASE_ADDR+index; next cycle ->WAIT; i2c_req stays high through WAIT.
REQ-021 WAIT->STORE on i2c_done, i2c_err, or timeout counter reaching TIMEOUT-1; i2c_req low from the following cycle.
REQ-022 i2c_done and i2c_err in same cycle: treated as error.
REQ-023 STORE on success: temps[index]<=captured i2c_rdata, valid[index]<=1; on error/timeout: temps[index] unchanged, valid[index]<=0.
REQ-024 NEXT: if index==NUM_SENSORS-1 or enable low -> IDLE, busy low, scan_done pulse; else index+1 -> REQ.
REQ-025 Ticks arriving while not in IDLE are dropped, not queued.
REQ-026 enable deasserted mid-transaction: current transaction completes and is stored; no further sensors started.
REQ-027 i2c_done/i2c_err outside WAIT ignored.
REQ-028 i2c_rdata sampled in the i2c_done cycle; temps updated the next edge (1-cycle latency).

Reset
REQ-029 On reset: FSM IDLE, index 0, counters 0, i2c_req 0, i2c_addr BASE_ADDR, temps 0, valid 0, busy 0, scan_done 0.
REQ-030 Reset mid-transaction drops i2c_req the next edge; later i2c_done ignored.

Configuration
REQ-031 TEMP_POLL_MAX_EN defined: add outputs max_temp (16) and max_idx (3), updated at scan_done to the signed-largest valid reading (lowest index wins ties); unchanged if no valid sensor; reset to 0.
REQ-032 TEMP_POLL_MAX_EN undefined: those ports and logic absent; other behaviour identical.

Structure
REQ-033 Package temp_poll_pkg holds FSM state encoding, default BASE_ADDR, POLL_DIV, TIMEOUT.
REQ-034 Sub-module poll_timer implements the REQ-017 interval counter and tick.

Verification
REQ-035 NUM_SENSORS=8, POLL_DIV=100, enable=1, master answers done after 5 cycles with data 16'h0100+n -> 8 requests to 7'h48..7'h4F, temps as sent, valid=8'hFF, one scan_done.
REQ-036 Sensor 3 returns i2c_err -> valid=8'hF7, temps[3] keeps prior value, scan continues to sensor 7.
REQ-037 Sensor 5 never responds, TIMEOUT=20 -> i2c_req drops after 20 WAIT cycles, valid[5]=0.
REQ-038 enable low while sensor 2 in WAIT -> sensor 2 stored, no request to 7'h4B, scan_done pulses, busy low.
REQ-039 reset asserted during WAIT, then stray i2c_done -> all outputs at reset values, temps stay 0.
REQ-040 TEMP_POLL_MAX_EN, readings 16'h0010,16'h0F00,16'hFF00,rest 16'h0005 -> max_temp=16'h0F00, max_idx=1.
